bbox_extractor: RTL

Inverse of the sprite renderers: consumes a per-pixel match mask in raster order and, once per frame, reports the bounding box of all matching pixels. The result uses the same `x`/`y`/`xmax`/`ymax` geometry the block sprites take, so the outputs drive a sprite directly and outline a detected object. It sits between the colour-threshold stage of the camera pipeline and the sprite/overlay stage.

---
 rtl/bbox_pkg.sv | 27 ++
 rtl/bbox_axis_tracker.sv | 69 ++++++
 rtl/bbox_extractor.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/bbox_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bbox_pkg
//  Description : Shared constants and types for the bounding-box extractor:
//                default active-area size, coordinate/area widths and the
//                two-state result FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package bbox_pkg;

    localparam int c_H_ACTIVE_DEF = 1280;
    localparam int c_V_ACTIVE_DEF = 720;

    // Raw counter widths and box widths (one extra bit for the exclusive edge).
    localparam int c_HC_W   = 11;
    localparam int c_VC_W   = 10;
    localparam int c_X_W    = c_HC_W + 1;
    localparam int c_Y_W    = c_VC_W + 1;
    localparam int c_AREA_W = 20;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        FINAL = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bbox_axis_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : bbox_axis_tracker
//  Description : One-dimensional extent tracker. Keeps the minimum position
//                and the exclusive maximum (largest position + 1) seen since
//                the last clear/load.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_clear         - empty the extent (min = all ones, maxe = 0)
//                i_load          - restart the extent at i_pos
//                i_update        - widen the extent to include i_pos
//                i_pos           - coordinate of the current pixel
//                o_min_nxt       - next-state minimum (for snapshotting)
//                o_maxe_nxt      - next-state exclusive maximum
//  Revision    : 1.0 - initial release
// ============================================================================
module bbox_axis_tracker
    import bbox_pkg::*;
#(
    parameter int IN_W = c_HC_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clear,
    input  logic            i_load,
    input  logic            i_update,
    input  logic [IN_W-1:0] i_pos,
    output logic [IN_W:0]   o_min_nxt,
    output logic [IN_W:0]   o_maxe_nxt
);

    logic [IN_W:0] r_min;
    logic [IN_W:0] r_maxe;
    logic [IN_W:0] w_pos;
    logic [IN_W:0] w_pos_p1;

    assign w_pos    = {1'b0, i_pos};
    assign w_pos_p1 = w_pos + {{IN_W{1'b0}}, 1'b1};

    always_comb begin
        o_min_nxt  = r_min;
        o_maxe_nxt = r_maxe;
        if (i_clear) begin
            o_min_nxt  = '1;
            o_maxe_nxt = '0;
        end else if (i_load) begin
            o_min_nxt  = w_pos;
            o_maxe_nxt = w_pos_p1;
        end else if (i_update) begin
            if (w_pos < r_min) begin
                o_min_nxt = w_pos;
            end
            if (w_pos_p1 > r_maxe) begin
                o_maxe_nxt = w_pos_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_min  <= '1;
            r_maxe <= '0;
        end else begin
            r_min  <= o_min_nxt;
            r_maxe <= o_maxe_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bbox_extractor.sv
`default_nettype none
// ============================================================================
//  Module      : bbox_extractor
//  Description : Consumes a raster-order match mask and, once per frame,
//                reports the bounding box of all matching pixels in sprite
//                geometry (centre x/y, exclusive right/bottom edges), the
//                matching-pixel count and a found flag.
//  Ports       : clk_in, rst_in              - pixel clock, sync active-high reset
//                valid_in, hcount_in,
//                vcount_in, mask_in          - pixel stream
//                x_out, y_out                - box centre (floor of mid-point)
//                xmax_out, ymax_out          - exclusive right / bottom edge
//                area_out                    - matching pixels in last frame
//                found_out                   - area_out >= MIN_AREA
//                valid_out                   - one-cycle update strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module bbox_extractor
    import bbox_pkg::*;
#(
    parameter int H_ACTIVE = c_H_ACTIVE_DEF,
    parameter int V_ACTIVE = c_V_ACTIVE_DEF,
    parameter int MIN_AREA = 64
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                valid_in,
    input  logic [c_HC_W-1:0]   hcount_in,
    input  logic [c_VC_W-1:0]   vcount_in,
    input  logic                mask_in,
    output logic [c_X_W-1:0]    x_out,
    output logic [c_Y_W-1:0]    y_out,
    output logic [c_X_W-1:0]    xmax_out,
    output logic [c_Y_W-1:0]    ymax_out,
    output logic [c_AREA_W-1:0] area_out,
    output logic                found_out,
    output logic                valid_out
);

    localparam logic [c_HC_W-1:0] c_H_LAST = c_HC_W'(H_ACTIVE - 1);
    localparam logic [c_VC_W-1:0] c_V_LAST = c_VC_W'(V_ACTIVE - 1);

    // ---------------- stage 1: register pixel and classify position --------
    logic              r_s1_valid;
    logic [c_HC_W-1:0] r_s1_h;
    logic [c_VC_W-1:0] r_s1_v;
    logic              r_s1_mask;
    logic              r_s1_first;
    logic              r_s1_last;
    logic              r_s1_in_range;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_s1_valid    <= 1'b0;
            r_s1_h        <= '0;
            r_s1_v        <= '0;
            r_s1_mask     <= 1'b0;
            r_s1_first    <= 1'b0;
            r_s1_last     <= 1'b0;
            r_s1_in_range <= 1'b0;
        end else begin
            r_s1_valid    <= valid_in;
            r_s1_h        <= hcount_in;
            r_s1_v        <= vcount_in;
            r_s1_mask     <= mask_in;
            r_s1_first    <= (hcount_in == '0) && (vcount_in == '0);
            r_s1_last     <= (hcount_in == c_H_LAST) && (vcount_in == c_V_LAST);
            r_s1_in_range <= (32'(hcount_in) < 32'(H_ACTIVE)) &&
                             (32'(vcount_in) < 32'(V_ACTIVE));
        end
    end

    // ---------------- stage 2: accumulators --------------------------------
    // r_armed is set by a frame's first pixel; pixels seen before that (after
    // reset or after a completed frame) belong to a frame whose start was
    // missed and must not contribute to, or trigger, a report.
    logic                r_armed;
    logic [c_AREA_W-1:0] r_area;
    logic [c_AREA_W-1:0] w_area_nxt;
    logic                w_first;
    logic                w_live;
    logic                w_hit;
    logic                w_last_evt;
    logic [c_X_W-1:0]    w_xmin_nxt;
    logic [c_X_W-1:0]    w_xmaxe_nxt;
    logic [c_Y_W-1:0]    w_ymin_nxt;
    logic [c_Y_W-1:0]    w_ymaxe_nxt;
    state_t              r_state;

    assign w_first    = r_s1_valid & r_s1_first;
    assign w_live     = r_s1_valid & r_s1_in_range & (r_armed | r_s1_first);
    assign w_hit      = w_live & r_s1_mask;
    assign w_last_evt = w_live & r_s1_last & (r_state == ACCUM);

    always_comb begin
        w_area_nxt = r_area;
        if (w_first) begin
            w_area_nxt = c_AREA_W'(r_s1_mask);
        end else if (w_hit) begin
            w_area_nxt = r_area + c_AREA_W'(1);
        end
    end

    bbox_axis_tracker #(
        .IN_W       (c_HC_W)
    ) u_x_tracker (
        .clk        (clk_in),
        .rst        (rst_in),
        .i_clear    (w_first & ~r_s1_mask),
        .i_load     (w_first & r_s1_mask),
        .i_update   (w_hit & ~w_first),
        .i_pos      (r_s1_h),
        .o_min_nxt  (w_xmin_nxt),
        .o_maxe_nxt (w_xmaxe_nxt)
    );

    bbox_axis_tracker #(
        .IN_W       (c_VC_W)
    ) u_y_tracker (
        .clk        (clk_in),
        .rst        (rst_in),
        .i_clear    (w_first & ~r_s1_mask),
        .i_load     (w_first & r_s1_mask),
        .i_update   (w_hit & ~w_first),
        .i_pos      (r_s1_v),
        .o_min_nxt  (w_ymin_nxt),
        .o_maxe_nxt (w_ymaxe_nxt)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_area  <= '0;
            r_armed <= 1'b0;
        end else begin
            r_area <= w_area_nxt;
            if (w_last_evt) begin
                r_armed <= 1'b0;
            end else if (w_first) begin
                r_armed <= 1'b1;
            end
        end
    end

    // ---------------- snapshot, FSM and result registers -------------------
    // The snapshot takes the accumulator next-state, so the last pixel is
    // included and a following frame may start accumulating immediately.
    logic [c_X_W-1:0]    r_snap_xmin;
    logic [c_X_W-1:0]    r_snap_xmaxe;
    logic [c_Y_W-1:0]    r_snap_ymin;
    logic [c_Y_W-1:0]    r_snap_ymaxe;
    logic [c_AREA_W-1:0] r_snap_area;
    logic                w_snap_found;

    logic [c_X_W-1:0]    r_x_out;
    logic [c_Y_W-1:0]    r_y_out;
    logic [c_X_W-1:0]    r_xmax_out;
    logic [c_Y_W-1:0]    r_ymax_out;
    logic [c_AREA_W-1:0] r_area_out;
    logic                r_found_out;
    logic                r_valid_out;

    assign w_snap_found = (32'(r_snap_area) >= 32'(MIN_AREA));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= ACCUM;
            r_snap_xmin  <= '0;
            r_snap_xmaxe <= '0;
            r_snap_ymin  <= '0;
            r_snap_ymaxe <= '0;
            r_snap_area  <= '0;
            r_x_out      <= '0;
            r_y_out      <= '0;
            r_xmax_out   <= '0;
            r_ymax_out   <= '0;
            r_area_out   <= '0;
            r_found_out  <= 1'b0;
            r_valid_out  <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            case (r_state)
                ACCUM: begin
                    if (w_last_evt) begin
                        r_state      <= FINAL;
                        r_snap_xmin  <= w_xmin_nxt;
                        r_snap_xmaxe <= w_xmaxe_nxt;
                        r_snap_ymin  <= w_ymin_nxt;
                        r_snap_ymaxe <= w_ymaxe_nxt;
                        r_snap_area  <= w_area_nxt;
                    end
                end
                FINAL: begin
                    r_state     <= ACCUM;
                    r_valid_out <= 1'b1;
                    r_area_out  <= r_snap_area;
                    r_found_out <= w_snap_found;
                    // Box outputs keep the last detected object when nothing
                    // is found, so an attached sprite does not jump.
                    if (w_snap_found) begin
                        // Widen by one bit before adding; floor mid-point.
                        r_x_out    <= c_X_W'(({1'b0, r_snap_xmin} + {1'b0, r_snap_xmaxe}) >> 1);
                        r_y_out    <= c_Y_W'(({1'b0, r_snap_ymin} + {1'b0, r_snap_ymaxe}) >> 1);
                        r_xmax_out <= r_snap_xmaxe;
                        r_ymax_out <= r_snap_ymaxe;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign x_out     = r_x_out;
    assign y_out     = r_y_out;
    assign xmax_out  = r_xmax_out;
    assign ymax_out  = r_ymax_out;
    assign area_out  = r_area_out;
    assign found_out = r_found_out;
    assign valid_out = r_valid_out;

endmodule
`default_nettype wire
